// File: rtl/key_debounce_if.sv
// Key debouncer signal bundle: raw key input towards the debouncer,
// clean level and one-cycle event pulses back to the consumer.
interface key_debounce_if;
    logic key_in;
    logic key_level;
    logic key_press;
    logic key_release;
    logic key_long;

    modport master (
        output key_in,
        input  key_level,
        input  key_press,
        input  key_release,
        input  key_long
    );

    modport slave (
        input  key_in,
        output key_level,
        output key_press,
        output key_release,
        output key_long
    );
endinterface

// File: rtl/key_debounce.sv
// Debounces one asynchronous key input: 2-flop synchronizer, 4-state filter FSM,
// registered level plus press/release/long-press one-cycle pulses.
module key_debounce #(
    parameter int DEB_CNT        = 4,
    parameter int LONG_CNT       = 20,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input logic          clk,
    input logic          rst_n,
    key_debounce_if.slave kif
);

    localparam int DW = $clog2(DEB_CNT + 1);
    localparam int LW = (LONG_CNT > 0) ? $clog2(LONG_CNT + 1) : 1;
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CNT - 1);
    localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_CNT);
    localparam logic [LW-1:0] LONG_LAST = LW'((LONG_CNT > 0) ? LONG_CNT - 1 : 0);
    localparam bit            LONG_EN   = (LONG_CNT > 0);

    typedef enum logic [1:0] {
        IDLE,
        FILT_DN,
        PRESSED,
        FILT_UP
    } state_e;

    logic          sync1_q, sync2_q;
    logic          key_act;
    state_e        state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] long_cnt_q, long_cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          held;

    assign key_act = sync2_q ^ KEY_ACTIVE_LOW;
    assign held    = (state_q == PRESSED) || (state_q == FILT_UP);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        long_cnt_d = long_cnt_q;
        case (state_q)
            IDLE: begin
                if (key_act) begin
                    state_d = FILT_DN;
                    cnt_d   = '0;
                end
            end
            FILT_DN: begin
                if (!key_act)               state_d = IDLE;
                else if (cnt_q == DEB_LAST) state_d = PRESSED;
                else                        cnt_d   = cnt_q + DW'(1);
            end
            PRESSED: begin
                if (!key_act) begin
                    state_d = FILT_UP;
                    cnt_d   = '0;
                end
            end
            FILT_UP: begin
                if (key_act)                state_d = PRESSED;
                else if (cnt_q == DEB_LAST) state_d = IDLE;
                else                        cnt_d   = cnt_q + DW'(1);
            end
            default: state_d = IDLE;
        endcase

        // Short release glitches (FILT_UP) keep the long-press count running.
        if (state_q == FILT_DN && state_d == PRESSED)
            long_cnt_d = '0;
        else if (held && long_cnt_q != LONG_MAX)
            long_cnt_d = long_cnt_q + LW'(1);

        level_d   = (state_d == PRESSED) || (state_d == FILT_UP);
        press_d   = (state_q == FILT_DN) && (state_d == PRESSED);
        release_d = (state_q == FILT_UP) && (state_d == IDLE);
        // A long press that completes on the same edge as the release is dropped.
        long_d    = LONG_EN && held && (long_cnt_q == LONG_LAST) && (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q    <= KEY_ACTIVE_LOW;
            sync2_q    <= KEY_ACTIVE_LOW;
            state_q    <= IDLE;
            cnt_q      <= '0;
            long_cnt_q <= '0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            sync1_q    <= kif.key_in;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            long_cnt_q <= long_cnt_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
        end
    end

    assign kif.key_level   = level_q;
    assign kif.key_press   = press_q;
    assign kif.key_release = release_q;
    assign kif.key_long    = long_q;

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: stimulus queues expected output events,
// a negedge monitor pops and compares whenever a pulse fires or the level changes.
module tb_key_debounce;

    localparam int DEB = 4;
    localparam int LNG = 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    key_debounce_if kif ();

    key_debounce #(
        .DEB_CNT        (DEB),
        .LONG_CNT       (LNG),
        .KEY_ACTIVE_LOW (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kif   (kif)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct packed {
        int   edge_no;
        logic press;
        logic rel;
        logic lng;
        logic level;
    } ev_t;

    ev_t  exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    logic last_level = 1'b0;
    ev_t  obs_ev, exp_ev;

    task automatic expect_ev(input int e, input logic p, input logic r, input logic l, input logic lv);
        ev_t ev;
        ev.edge_no = e;
        ev.press   = p;
        ev.rel     = r;
        ev.lng     = l;
        ev.level   = lv;
        exp_q.push_back(ev);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (mon_en && (kif.key_press || kif.key_release || kif.key_long || kif.key_level !== last_level)) begin
            obs_ev.edge_no = edge_cnt;
            obs_ev.press   = kif.key_press;
            obs_ev.rel     = kif.key_release;
            obs_ev.lng     = kif.key_long;
            obs_ev.level   = kif.key_level;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got edge=%0d press=%b release=%b long=%b level=%b, expected no event",
                         obs_ev.edge_no, obs_ev.press, obs_ev.rel, obs_ev.lng, obs_ev.level);
            end else begin
                exp_ev = exp_q.pop_front();
                if (obs_ev !== exp_ev) begin
                    errors++;
                    $display("FAIL event: got edge=%0d press=%b release=%b long=%b level=%b, expected edge=%0d press=%b release=%b long=%b level=%b",
                             obs_ev.edge_no, obs_ev.press, obs_ev.rel, obs_ev.lng, obs_ev.level,
                             exp_ev.edge_no, exp_ev.press, exp_ev.rel, exp_ev.lng, exp_ev.level);
                end
            end
            last_level = kif.key_level;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int r0;
        int ex;
        logic [3:0] outs;

        // 1: reset with key_in=0, then idle with key released
        kif.key_in = 1'b0;
        rst_n      = 1'b0;
        cycles(3);
        outs = {kif.key_level, kif.key_press, kif.key_release, kif.key_long};
        checks++;
        if (outs !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b, expected 0000", outs);
        end
        rst_n      = 1'b1;
        kif.key_in = 1'b1;
        mon_en     = 1'b1;
        cycles(20);

        // 2: clean press of 15 cycles, then release
        e0 = edge_cnt + 1;
        kif.key_in = 1'b0;
        expect_ev(e0 + DEB + 2, 1'b1, 1'b0, 1'b0, 1'b1);
        cycles(15);
        r0 = edge_cnt + 1;
        kif.key_in = 1'b1;
        expect_ev(r0 + DEB + 2, 1'b0, 1'b1, 1'b0, 1'b0);
        cycles(20);

        // 3: bounce 0,0,0,1 then stable 0
        kif.key_in = 1'b0;
        cycles(3);
        kif.key_in = 1'b1;
        cycles(1);
        ex = edge_cnt + 1;
        kif.key_in = 1'b0;
        expect_ev(ex + DEB + 2, 1'b1, 1'b0, 1'b0, 1'b1);
        cycles(12);
        r0 = edge_cnt + 1;
        kif.key_in = 1'b1;
        expect_ev(r0 + DEB + 2, 1'b0, 1'b1, 1'b0, 1'b0);
        cycles(20);

        // 4: long press of 40 cycles
        e0 = edge_cnt + 1;
        kif.key_in = 1'b0;
        expect_ev(e0 + DEB + 2,       1'b1, 1'b0, 1'b0, 1'b1);
        expect_ev(e0 + DEB + 2 + LNG, 1'b0, 1'b0, 1'b1, 1'b1);
        cycles(40);
        r0 = edge_cnt + 1;
        kif.key_in = 1'b1;
        expect_ev(r0 + DEB + 2, 1'b0, 1'b1, 1'b0, 1'b0);
        cycles(20);

        // 5: 2-cycle release glitch while pressed
        e0 = edge_cnt + 1;
        kif.key_in = 1'b0;
        expect_ev(e0 + DEB + 2,       1'b1, 1'b0, 1'b0, 1'b1);
        expect_ev(e0 + DEB + 2 + LNG, 1'b0, 1'b0, 1'b1, 1'b1);
        cycles(10);
        kif.key_in = 1'b1;
        cycles(2);
        kif.key_in = 1'b0;
        cycles(28);
        r0 = edge_cnt + 1;
        kif.key_in = 1'b1;
        expect_ev(r0 + DEB + 2, 1'b0, 1'b1, 1'b0, 1'b0);
        cycles(20);

        // 6: reset pulse at e0+11 during a press, key still held
        e0 = edge_cnt + 1;
        kif.key_in = 1'b0;
        expect_ev(e0 + DEB + 2, 1'b1, 1'b0, 1'b0, 1'b1);
        cycles(11);
        rst_n = 1'b0;
        expect_ev(e0 + 11, 1'b0, 1'b0, 1'b0, 1'b0);
        cycles(1);
        rst_n = 1'b1;
        expect_ev(e0 + 12 + DEB + 2, 1'b1, 1'b0, 1'b0, 1'b1);
        cycles(14);
        r0 = edge_cnt + 1;
        kif.key_in = 1'b1;
        expect_ev(r0 + DEB + 2, 1'b0, 1'b1, 1'b0, 1'b0);
        cycles(20);

        while (exp_q.size() != 0) begin
            exp_ev = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event: got nothing, expected edge=%0d press=%b release=%b long=%b level=%b",
                     exp_ev.edge_no, exp_ev.press, exp_ev.rel, exp_ev.lng, exp_ev.level);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Debounces one asynchronous mechanical key/switch input and emits clean level, press, release and long-press indications.
- Sits directly upstream of the team's rising-edge pulse shaper; its key_level output is the clean, single-clock-domain level that the shaper samples.
- Also exports its own one-cycle press/release/long pulses for consumers that do not need a separate shaper.

Parameters:
DEB_CNT, 4, consecutive stable cycles required to accept a level change; legal range >=1.
LONG_CNT, 20, cycles after key_press at which key_long fires; 0 disables long-press detection.
KEY_ACTIVE_LOW, 1, 1 = key_in is active when 0; 0 = key_in is active when 1.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
key_in  input  1  raw asynchronous key input
key_level  output  1  debounced level, 1 = pressed
key_press  output  1  one-cycle pulse on accepted press
key_release  output  1  one-cycle pulse on accepted release
key_long  output  1  one-cycle pulse on long press, at most once per press

Behaviour:
- Reset: rst_n=0 at a clk edge puts all outputs to 0, FSM to IDLE and all counters to 0. Both synchronizer flops load the inactive level (1 if KEY_ACTIVE_LOW=1, else 0). Reset overrides every event.
- Sync path: key_in goes through 2 flops, sync1 then sync2. key_act = sync2 XOR KEY_ACTIVE_LOW.
- Edge numbering: e0 is the first edge at which sync1 captures the active level. key_act=1 after e1.
- FSM states:
  - IDLE: key_level=0. key_act=1 -> FILT_DN, cnt=0.
  - FILT_DN: key_act=0 -> IDLE, with no pulse. key_act=1 and cnt==DEB_CNT-1 -> PRESSED. Otherwise cnt++.
  - PRESSED: key_act=0 -> FILT_UP, cnt=0.
  - FILT_UP: key_act=1 -> PRESSED, with no pulse and no second key_press. key_act=0 and cnt==DEB_CNT-1 -> IDLE. Otherwise cnt++.
- All outputs are registered.
  - key_level is 1 in PRESSED and FILT_UP, 0 in IDLE and FILT_DN.
  - key_press=1 only in the cycle after the FILT_DN->PRESSED edge.
  - key_release=1 only in the cycle after the FILT_UP->IDLE edge.
- Latency: for a stable input, key_level and key_press assert after edge e0+DEB_CNT+2. Release timing is symmetric: key_release asserts DEB_CNT+2 edges after the first edge at which sync1 captures the inactive level.
- Bounce: any opposite sample during FILT_DN or FILT_UP aborts the filter. The count restarts from 0 on the next qualifying entry.
- Long press counter (long_cnt):
  - Cleared on the FILT_DN->PRESSED edge.
  - Increments every cycle in PRESSED or FILT_UP, saturating at LONG_CNT.
  - Release glitches shorter than DEB_CNT do not clear it.
- key_long: pulses for 1 cycle when long_cnt transitions LONG_CNT-1 -> LONG_CNT. This places it exactly LONG_CNT cycles after key_press.
  - Never fires if IDLE is reached first.
  - Never fires twice per press.
  - Never fires when LONG_CNT=0.
- Counter widths: $clog2(DEB_CNT+1) and $clog2(LONG_CNT+1), minimum 1 bit. No counter wraps.
- Simultaneity: key_press and key_release are never high in the same cycle. key_long may coincide with neither.
- Reset mid-press: outputs drop to 0 on the reset edge. No key_release is generated, and after reset the FSM starts in IDLE.

Test Plan (DEB_CNT=4, LONG_CNT=20, KEY_ACTIVE_LOW=1):
1. Reset for 3 cycles with key_in=0 -> all outputs 0. After reset is released with key_in=1, outputs stay 0 indefinitely.
2. key_in=0 from e0, held 15 cycles, then key_in=1 -> key_press=1 for exactly 1 cycle after e6, with key_level=1 from then on. key_release pulses 6 edges after the first edge at which sync1 captures 1. key_long never fires.
3. Bounce: key_in=0 for 3 cycles, 1 for 1 cycle, then 0 stable from edge eX -> no key_press after the first burst. Exactly one key_press, after eX+6.
4. Long press: key_in=0 held 40 cycles -> key_press at e6, key_long single pulse exactly 20 cycles later, no further key_long.
5. Release glitch while PRESSED: key_in=1 for 2 cycles, then 0 -> key_level stays 1. No key_release, no second key_press, key_long timing unchanged.
6. rst_n=0 for 1 cycle at e6+5 during a press -> key_level drops to 0 on the reset edge. No key_release afterward. After rst_n=1 with key_in still 0, a fresh key_press comes 6 edges later.
